// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS core.
// Sequences fetch/decode/execute/memory/writeback over a shared ALU, register
// file and unified memory. Memory states wait on mem_ready under a watchdog
// that parks the FSM in a sticky FAULT state. Undecodable opcodes and R-type
// functs raise a one-cycle illegal_op pulse.
// Build option: define MIPS_CTRL_LOGIC_IMM_EN to also execute andi/ori
// (zero-extended immediate, and/or ALU op); otherwise those are illegal.
module mips_multicycle_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_req,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] pc_src,
  output logic       ext_sign,
  output logic       illegal_op,
  output logic       fault
);

`ifdef MIPS_CTRL_LOGIC_IMM_EN
  localparam bit LOGIC_IMM_EN = 1'b1;
`else
  localparam bit LOGIC_IMM_EN = 1'b0;
`endif

  localparam logic [7:0] WAIT_LIM = MAX_WAIT[7:0];

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPEEX,
    S_ALUWB, S_BEQ, S_IMMEX, S_IMMWB, S_JUMP, S_FAULT
  } state_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic [5:0] op_q;
  logic [5:0] funct_q;

  // R-type funct decode: {valid, alu_control}; unknown functs fall back to add
  function automatic logic [3:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100000: rtype_alu = {1'b1, ALU_ADD};
      6'b100010: rtype_alu = {1'b1, ALU_SUB};
      6'b100100: rtype_alu = {1'b1, ALU_AND};
      6'b100101: rtype_alu = {1'b1, ALU_OR};
      6'b101010: rtype_alu = {1'b1, ALU_SLT};
      default:   rtype_alu = {1'b0, ALU_ADD};
    endcase
  endfunction

  // Immediate-op decode: {ext_sign, alu_control}; logical ops zero-extend
  function automatic logic [3:0] imm_alu(input logic [5:0] o);
    case (o)
      OP_SLTI: imm_alu = {1'b1, ALU_SLT};
      OP_ANDI: imm_alu = {1'b0, ALU_AND};
      OP_ORI:  imm_alu = {1'b0, ALU_OR};
      default: imm_alu = {1'b1, ALU_ADD};
    endcase
  endfunction

  logic [3:0] r_dec;
  logic [3:0] i_dec;
  assign r_dec = rtype_alu(funct_q);
  assign i_dec = imm_alu(op_q);

  // State sequencing, memory-wait watchdog, sticky fault and illegal pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_FETCH;
      wait_cnt   <= '0;
      fault      <= 1'b0;
      illegal_op <= 1'b0;
      op_q       <= '0;
      funct_q    <= '0;
    end else begin
      illegal_op <= 1'b0;
      wait_cnt   <= '0;
      case (state)
        S_FETCH, S_MEMRD, S_MEMWR: begin
          // ready wins over the watchdog, even at the final allowed count
          if (mem_ready) begin
            state <= (state == S_FETCH) ? S_DECODE :
                     (state == S_MEMRD) ? S_MEMWB  : S_FETCH;
          end else if (wait_cnt == WAIT_LIM) begin
            state <= S_FAULT;
            fault <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          op_q    <= op;
          funct_q <= funct;
          case (op)
            OP_LW, OP_SW:     state <= S_MEMADR;
            OP_RTYPE:         state <= S_RTYPEEX;
            OP_BEQ:           state <= S_BEQ;
            OP_ADDI, OP_SLTI: state <= S_IMMEX;
            OP_J:             state <= S_JUMP;
            OP_ANDI, OP_ORI: begin
              if (LOGIC_IMM_EN) begin
                state <= S_IMMEX;
              end else begin
                illegal_op <= 1'b1;
                state      <= S_FETCH;
              end
            end
            default: begin
              illegal_op <= 1'b1;
              state      <= S_FETCH;
            end
          endcase
        end
        S_MEMADR: state <= (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
        S_RTYPEEX: begin
          if (r_dec[3]) begin
            state <= S_ALUWB;
          end else begin
            illegal_op <= 1'b1;
            state      <= S_FETCH;
          end
        end
        S_IMMEX: state <= S_IMMWB;
        S_FAULT: state <= S_FAULT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Moore datapath controls; only pc_en/ir_write are qualified by mem_ready/zero.
  // Held inactive while reset_n is low so an in-flight access drops immediately.
  always_comb begin
    pc_en       = 1'b0;
    iord        = 1'b0;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    pc_src      = 2'b00;
    ext_sign    = 1'b1;
    if (reset_n) begin
      case (state)
        S_FETCH: begin
          mem_req     = 1'b1;
          alu_src_b   = 2'b01;
          alu_control = ALU_ADD;
          ir_write    = mem_ready;
          pc_en       = mem_ready;
        end
        S_DECODE: begin
          alu_src_b   = 2'b11;
          alu_control = ALU_ADD;
        end
        S_MEMADR: begin
          alu_src_a   = 1'b1;
          alu_src_b   = 2'b10;
          alu_control = ALU_ADD;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWR: begin
          mem_req   = 1'b1;
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_RTYPEEX: begin
          alu_src_a   = 1'b1;
          alu_control = r_dec[2:0];
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BEQ: begin
          alu_src_a   = 1'b1;
          alu_control = ALU_SUB;
          pc_src      = 2'b01;
          pc_en       = zero;
        end
        S_IMMEX: begin
          alu_src_a   = 1'b1;
          alu_src_b   = 2'b10;
          alu_control = i_dec[2:0];
          ext_sign    = i_dec[3];
        end
        S_IMMWB: reg_write = 1'b1;
        S_JUMP: begin
          pc_src = 2'b10;
          pc_en  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-cycle output snapshots against
// hand-derived vectors. Snapshot order:
// {pc_en,iord,mem_req,mem_write,ir_write,reg_write,reg_dst,mem_to_reg,
//  alu_src_a,alu_src_b,alu_control,pc_src,ext_sign,illegal_op,fault}
module tb_mips_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] op = 6'b0;
  logic [5:0] funct = 6'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, iord, mem_req, mem_write, ir_write, reg_write, reg_dst;
  logic       mem_to_reg, alu_src_a, ext_sign, illegal_op, fault;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [18:0] obs;
  int checks = 0;
  int passed = 0;

  mips_multicycle_ctrl #(.MAX_WAIT(15)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_req(mem_req),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .pc_src(pc_src),
    .ext_sign(ext_sign), .illegal_op(illegal_op), .fault(fault)
  );

  always #5 clk = ~clk;

  assign obs = {pc_en, iord, mem_req, mem_write, ir_write, reg_write, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, alu_control, pc_src,
                ext_sign, illegal_op, fault};

  localparam logic [18:0] V_RESET  = {9'b000000000, 2'b00, 3'b000, 2'b00, 3'b100};
  localparam logic [18:0] V_FETCHR = {9'b101010000, 2'b01, 3'b010, 2'b00, 3'b100};
  localparam logic [18:0] V_FETCHW = {9'b001000000, 2'b01, 3'b010, 2'b00, 3'b100};
  localparam logic [18:0] V_FETCHI = {9'b001000000, 2'b01, 3'b010, 2'b00, 3'b110};
  localparam logic [18:0] V_DECODE = {9'b000000000, 2'b11, 3'b010, 2'b00, 3'b100};
  localparam logic [18:0] V_MEMADR = {9'b000000001, 2'b10, 3'b010, 2'b00, 3'b100};
  localparam logic [18:0] V_MEMRD  = {9'b011000000, 2'b00, 3'b000, 2'b00, 3'b100};
  localparam logic [18:0] V_MEMWR  = {9'b011100000, 2'b00, 3'b000, 2'b00, 3'b100};
  localparam logic [18:0] V_MEMWB  = {9'b000001010, 2'b00, 3'b000, 2'b00, 3'b100};
  localparam logic [18:0] V_RBAD   = {9'b000000001, 2'b00, 3'b010, 2'b00, 3'b100};
  localparam logic [18:0] V_ALUWB  = {9'b000001100, 2'b00, 3'b000, 2'b00, 3'b100};
  localparam logic [18:0] V_BEQT   = {9'b100000001, 2'b00, 3'b110, 2'b01, 3'b100};
  localparam logic [18:0] V_BEQN   = {9'b000000001, 2'b00, 3'b110, 2'b01, 3'b100};
  localparam logic [18:0] V_IADD   = {9'b000000001, 2'b10, 3'b010, 2'b00, 3'b100};
  localparam logic [18:0] V_ISLT   = {9'b000000001, 2'b10, 3'b111, 2'b00, 3'b100};
  localparam logic [18:0] V_IORI   = {9'b000000001, 2'b10, 3'b001, 2'b00, 3'b000};
  localparam logic [18:0] V_IMMWB  = {9'b000001000, 2'b00, 3'b000, 2'b00, 3'b100};
  localparam logic [18:0] V_JUMP   = {9'b100000000, 2'b00, 3'b000, 2'b10, 3'b100};
  localparam logic [18:0] V_FAULT  = {9'b000000000, 2'b00, 3'b000, 2'b00, 3'b101};

  task automatic do_reset();
    reset_n = 1'b0;
    mem_ready = 1'b0;
    zero = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    mem_ready = 1'b1;
    #3;
    if (obs !== V_RESET) $display("FAIL reset_hold: got %b expected %b", obs, V_RESET);
    else passed++;
    checks++;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    reset_n = 1'b1;
    #2;
    if (obs !== V_FETCHW) $display("FAIL reset_release: got %b expected %b", obs, V_FETCHW);
    else passed++;
    checks++;
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    logic [18:0] ex [6] = '{V_FETCHR, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB, V_FETCHW};
    logic        rd [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    op = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      mem_ready = rd[i];
      #2;
      if (obs !== ex[i]) $display("FAIL lw[%0d]: got %b expected %b", i, obs, ex[i]);
      else passed++;
      checks++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_wait();
    logic [18:0] ex [8] = '{V_FETCHR, V_DECODE, V_MEMADR, V_MEMRD, V_MEMRD, V_MEMRD,
                            V_MEMWB, V_FETCHW};
    logic        rd [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    op = 6'b100011;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rd[i];
      #2;
      if (obs !== ex[i]) $display("FAIL lw_wait[%0d]: got %b expected %b", i, obs, ex[i]);
      else passed++;
      checks++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    logic [18:0] ex [5] = '{V_FETCHR, V_DECODE, V_MEMADR, V_MEMWR, V_FETCHW};
    logic        rd [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    op = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rd[i];
      #2;
      if (obs !== ex[i]) $display("FAIL sw[%0d]: got %b expected %b", i, obs, ex[i]);
      else passed++;
      checks++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    logic [5:0]  fn [5]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0]  alu [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    logic [18:0] ex [4];
    op = 6'b000000;
    for (int k = 0; k < 5; k++) begin
      funct = fn[k];
      ex[0] = V_FETCHR;
      ex[1] = V_DECODE;
      ex[2] = {9'b000000001, 2'b00, alu[k], 2'b00, 3'b100};
      ex[3] = V_ALUWB;
      for (int i = 0; i < 4; i++) begin
        mem_ready = 1'b1;
        #2;
        if (obs !== ex[i]) $display("FAIL rtype_%0d[%0d]: got %b expected %b", k, i, obs, ex[i]);
        else passed++;
        checks++;
        @(posedge clk); #1;
      end
    end
    mem_ready = 1'b0;
    #2;
    if (obs !== V_FETCHW) $display("FAIL rtype_return: got %b expected %b", obs, V_FETCHW);
    else passed++;
    checks++;
    @(posedge clk); #1;
  endtask

  task automatic test_bad_funct();
    logic [18:0] ex [5] = '{V_FETCHR, V_DECODE, V_RBAD, V_FETCHI, V_FETCHW};
    logic        rd [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    op = 6'b000000;
    funct = 6'b111000;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rd[i];
      #2;
      if (obs !== ex[i]) $display("FAIL bad_funct[%0d]: got %b expected %b", i, obs, ex[i]);
      else passed++;
      checks++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    logic [18:0] ex [4];
    logic        rd [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    op = 6'b000100;
    for (int t = 0; t < 2; t++) begin
      zero = (t == 0);
      ex = '{V_FETCHR, V_DECODE, (t == 0) ? V_BEQT : V_BEQN, V_FETCHW};
      for (int i = 0; i < 4; i++) begin
        mem_ready = rd[i];
        #2;
        if (obs !== ex[i]) $display("FAIL beq_z%0d[%0d]: got %b expected %b", 1 - t, i, obs, ex[i]);
        else passed++;
        checks++;
        @(posedge clk); #1;
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_imm();
    logic [5:0]  ops [2] = '{6'b001000, 6'b001010};
    logic [18:0] exv [2] = '{V_IADD, V_ISLT};
    logic [18:0] ex [5];
    logic        rd [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      op = ops[k];
      ex = '{V_FETCHR, V_DECODE, exv[k], V_IMMWB, V_FETCHW};
      for (int i = 0; i < 5; i++) begin
        mem_ready = rd[i];
        #2;
        if (obs !== ex[i]) $display("FAIL imm_%0d[%0d]: got %b expected %b", k, i, obs, ex[i]);
        else passed++;
        checks++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_jump();
    logic [18:0] ex [4] = '{V_FETCHR, V_DECODE, V_JUMP, V_FETCHW};
    logic        rd [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    op = 6'b000010;
    for (int i = 0; i < 4; i++) begin
      mem_ready = rd[i];
      #2;
      if (obs !== ex[i]) $display("FAIL jump[%0d]: got %b expected %b", i, obs, ex[i]);
      else passed++;
      checks++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal_op();
    logic [18:0] ex [4] = '{V_FETCHR, V_DECODE, V_FETCHI, V_FETCHW};
    logic        rd [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    op = 6'b111111;
    for (int i = 0; i < 4; i++) begin
      mem_ready = rd[i];
      #2;
      if (obs !== ex[i]) $display("FAIL illegal_op[%0d]: got %b expected %b", i, obs, ex[i]);
      else passed++;
      checks++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_logic_imm();
`ifdef MIPS_CTRL_LOGIC_IMM_EN
    logic [18:0] ex [5] = '{V_FETCHR, V_DECODE, V_IORI, V_IMMWB, V_FETCHW};
    logic        rd [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
    logic [18:0] ex [5] = '{V_FETCHR, V_DECODE, V_FETCHI, V_FETCHW, V_FETCHW};
    logic        rd [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
    op = 6'b001101;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rd[i];
      #2;
      if (obs !== ex[i]) $display("FAIL ori[%0d]: got %b expected %b", i, obs, ex[i]);
      else passed++;
      checks++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_access();
    logic [18:0] ex [4] = '{V_FETCHR, V_DECODE, V_MEMADR, V_MEMRD};
    logic        rd [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    op = 6'b100011;
    for (int i = 0; i < 4; i++) begin
      mem_ready = rd[i];
      #2;
      if (obs !== ex[i]) $display("FAIL mid_rst_seq[%0d]: got %b expected %b", i, obs, ex[i]);
      else passed++;
      checks++;
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    #2;
    reset_n = 1'b0;
    #1;
    if (obs !== V_RESET) $display("FAIL mid_rst_drop: got %b expected %b", obs, V_RESET);
    else passed++;
    checks++;
    #1;
    reset_n = 1'b1;
    #1;
    if (obs !== V_FETCHW) $display("FAIL mid_rst_fetch: got %b expected %b", obs, V_FETCHW);
    else passed++;
    checks++;
    @(posedge clk); #1;
  endtask

  task automatic test_wait_accept();
    logic [18:0] ex [4] = '{V_FETCHR, V_DECODE, V_JUMP, V_FETCHW};
    logic        rd [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    op = 6'b000010;
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
    end
    #2;
    if (obs !== V_FETCHW) $display("FAIL wait15_still_fetch: got %b expected %b", obs, V_FETCHW);
    else passed++;
    checks++;
    for (int i = 0; i < 4; i++) begin
      mem_ready = rd[i];
      #2;
      if (obs !== ex[i]) $display("FAIL wait_accept[%0d]: got %b expected %b", i, obs, ex[i]);
      else passed++;
      checks++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_watchdog_fault();
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i != 0);
      #2;
      if (obs !== V_FAULT) $display("FAIL fault_sticky[%0d]: got %b expected %b", i, obs, V_FAULT);
      else passed++;
      checks++;
      @(posedge clk); #1;
    end
    do_reset();
    #2;
    if (obs !== V_FETCHW) $display("FAIL fault_cleared: got %b expected %b", obs, V_FETCHW);
    else passed++;
    checks++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lw_wait();
    test_sw();
    test_rtype();
    test_bad_funct();
    test_beq();
    test_imm();
    test_jump();
    test_illegal_op();
    test_logic_imm();
    test_reset_mid_access();
    test_wait_accept();
    test_watchdog_fault();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
